// File: rtl/tb_obi_pkg.sv
// tb_obi_pkg: shared types and helpers for the OBI memory responder.
package tb_obi_pkg;
   localparam int OBI_DATA_W   = 32;
   localparam int RESP_DELAY_W = 4;

   typedef struct packed {
      logic [OBI_DATA_W-1:0]   rdata;
      logic [RESP_DELAY_W-1:0] delay;
   } resp_entry_t;

   function automatic logic [OBI_DATA_W-1:0] be_merge(
      input logic [OBI_DATA_W-1:0]   old_w,
      input logic [OBI_DATA_W-1:0]   wdata,
      input logic [OBI_DATA_W/8-1:0] be
   );
      be_merge = old_w;
      for (int i = 0; i < OBI_DATA_W/8; i++)
         if (be[i]) be_merge[8*i +: 8] = wdata[8*i +: 8];
   endfunction
endpackage

// File: rtl/tb_obi_resp_fifo.sv
// tb_obi_resp_fifo: in-order FIFO of pending responses; exposes head and the entry behind it.
module tb_obi_resp_fifo
   import tb_obi_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   i_push,
   input  resp_entry_t            i_data,
   input  logic                   i_pop,
   output resp_entry_t            o_head,
   output resp_entry_t            o_next,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty
);
   localparam int AW = $clog2(DEPTH);

   resp_entry_t      r_mem [DEPTH];
   logic [AW-1:0]    r_wr, r_rd, w_rd_nxt;
   logic [AW:0]      r_count;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + 1'b1;
         if (i_pop) r_rd <= r_rd + 1'b1;
         if (i_push && !i_pop) r_count <= r_count + 1'b1;
         else if (!i_push && i_pop) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk_i)
      if (i_push) r_mem[r_wr] <= i_data;

   assign w_rd_nxt = r_rd + 1'b1;
   assign o_head   = r_mem[r_rd];
   assign o_next   = r_mem[w_rd_nxt];
   assign o_count  = r_count;
   assign o_full   = r_count == (AW+1)'(DEPTH);
   assign o_empty  = r_count == '0;
endmodule

// File: rtl/tb_obi_mem_responder.sv
// tb_obi_mem_responder: OBI memory-side responder with programmable grant stalls
// and in-order responses carrying per-transaction latency.
module tb_obi_mem_responder
   import tb_obi_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH  = 10,
   parameter int MAX_OUTSTANDING = 4,
   parameter int STALL_WIDTH     = RESP_DELAY_W
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               req_i,
   output logic                               gnt_o,
   input  logic [31:0]                        addr_i,
   input  logic                               we_i,
   input  logic [3:0]                         be_i,
   input  logic [31:0]                        wdata_i,
   output logic                               rvalid_o,
   output logic [31:0]                        rdata_o,
   input  logic [STALL_WIDTH-1:0]             gnt_stall_i,
   input  logic [STALL_WIDTH-1:0]             rvalid_stall_i,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o
);
   logic [OBI_DATA_W-1:0]         r_mem [2**MEM_ADDR_WIDTH];
   logic [MEM_ADDR_WIDTH-1:0]     w_idx;
   logic                          r_gbusy;
   logic [STALL_WIDTH-1:0]        r_gcnt, w_gcnt, r_hcnt;
   logic                          w_gnt, w_pop, w_full, w_empty;
   logic [$clog2(MAX_OUTSTANDING):0] w_count;
   logic [OBI_DATA_W-1:0]         r_rdata;
   resp_entry_t                   w_entry, w_head, w_next;
   logic                          w_unused;

   assign w_idx    = addr_i[MEM_ADDR_WIDTH+1:2];
   assign w_unused = ^{addr_i[31:MEM_ADDR_WIDTH+2], addr_i[1:0]};

   // An idle counter behaves as if already loaded, so a zero stall grants in the request cycle.
   assign w_gcnt = r_gbusy ? r_gcnt : gnt_stall_i;
   assign w_gnt  = req_i && w_gcnt == '0 && !w_full;
   assign gnt_o  = w_gnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_gbusy <= 1'b0;
         r_gcnt  <= '0;
      end else if (!req_i || w_gnt) begin
         r_gbusy <= 1'b0;
      end else begin
         r_gbusy <= 1'b1;
         r_gcnt  <= w_gcnt == '0 ? '0 : w_gcnt - 1'b1;
      end
   end

   always_ff @(posedge clk_i)
      if (w_gnt && we_i) r_mem[w_idx] <= be_merge(r_mem[w_idx], wdata_i, be_i);

   always_comb begin
      w_entry.rdata = we_i ? '0 : r_mem[w_idx];
      w_entry.delay = RESP_DELAY_W'(rvalid_stall_i);
   end

   tb_obi_resp_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_push  (w_gnt),
      .i_data  (w_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_next  (w_next),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Every FIFO entry was pushed at an earlier edge, so a zero head count may respond now.
   assign w_pop         = !w_empty && r_hcnt == '0;
   assign rvalid_o      = w_pop;
   assign rdata_o       = w_pop ? w_head.rdata : r_rdata;
   assign outstanding_o = w_count;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_hcnt  <= '0;
         r_rdata <= '0;
      end else if (w_pop) begin
         r_rdata <= w_head.rdata;
         r_hcnt  <= w_count > ($clog2(MAX_OUTSTANDING)+1)'(1) ? STALL_WIDTH'(w_next.delay)
                  : w_gnt ? STALL_WIDTH'(w_entry.delay) : '0;
      end else if (w_empty) begin
         r_hcnt  <= w_gnt ? STALL_WIDTH'(w_entry.delay) : '0;
      end else begin
         r_hcnt  <= r_hcnt - 1'b1;
      end
   end
endmodule

// File: tb/tb_tb_obi_mem_responder.sv
// tb_tb_obi_mem_responder: directed checks of grant stalls, byte enables, ordering,
// FIFO backpressure and asynchronous reset of the OBI responder.
module tb_tb_obi_mem_responder;
   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_i, we_i, gnt_o, rvalid_o;
   logic [3:0]  be_i, gnt_stall_i, rvalid_stall_i;
   logic [31:0] addr_i, wdata_i, rdata_o;
   logic [2:0]  outstanding_o;
   int          n_cmp = 0;
   int          n_fail = 0;

   tb_obi_mem_responder dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .req_i          (req_i),
      .gnt_o          (gnt_o),
      .addr_i         (addr_i),
      .we_i           (we_i),
      .be_i           (be_i),
      .wdata_i        (wdata_i),
      .rvalid_o       (rvalid_o),
      .rdata_o        (rdata_o),
      .gnt_stall_i    (gnt_stall_i),
      .rvalid_stall_i (rvalid_stall_i),
      .outstanding_o  (outstanding_o)
   );

   always #5 clk_i = ~clk_i;

   // Inputs change 1 time unit after a rising edge; outputs are sampled 4 units later.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      req_i = req; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
   endtask

   task automatic test_reset();
      #3;
      n_cmp += 4;
      if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL rst_gnt got=%b want=0", gnt_o); end
      if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got=%b want=0", rvalid_o); end
      if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h want=0", rdata_o); end
      if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL rst_outst got=%0d want=0", outstanding_o); end
      tick();
      tick();
      rst_ni = 1'b1;
   endtask

   task automatic test_zero_stall();
      drive(1, 1, 32'h100, 32'hDEADBEEF, 4'hF);
      #4;
      n_cmp++;
      if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL zs_wr_gnt got=%b want=1", gnt_o); end
      tick();
      drive(1, 0, 32'h100, 32'h0, 4'hF);
      #4;
      n_cmp += 3;
      if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL zs_rd_gnt got=%b want=1", gnt_o); end
      if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL zs_wr_rvalid got=%b want=1", rvalid_o); end
      if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL zs_wr_rdata got=%h want=0", rdata_o); end
      tick();
      req_i = 1'b0;
      #4;
      n_cmp += 2;
      if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL zs_rd_rvalid got=%b want=1", rvalid_o); end
      if (rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL zs_rd_rdata got=%h want=deadbeef", rdata_o); end
      tick();
      #4;
      n_cmp += 3;
      if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL zs_idle_rvalid got=%b want=0", rvalid_o); end
      if (rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL zs_hold_rdata got=%h want=deadbeef", rdata_o); end
      if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL zs_outst got=%0d want=0", outstanding_o); end
      tick();
   endtask

   task automatic test_byte_en();
      drive(1, 1, 32'h20, 32'h11223344, 4'hF);
      tick();
      drive(1, 1, 32'h20, 32'hAABBCCDD, 4'b0101);
      tick();
      drive(1, 0, 32'h20, 32'h0, 4'hF);
      #4;
      n_cmp++;
      if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL be_rd_gnt got=%b want=1", gnt_o); end
      tick();
      req_i = 1'b0;
      #4;
      n_cmp += 2;
      if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL be_rvalid got=%b want=1", rvalid_o); end
      if (rdata_o !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_rdata got=%h want=11bb33dd", rdata_o); end
      tick();
   endtask

   task automatic test_grant_stall();
      drive(1, 0, 32'h100, 32'h0, 4'hF);
      gnt_stall_i = 4'd3;
      for (int c = 1; c <= 4; c++) begin
         #4;
         n_cmp++;
         if (gnt_o !== (c == 4)) begin n_fail++; $display("FAIL gs_gnt_c%0d got=%b want=%b", c, gnt_o, c == 4); end
         tick();
         gnt_stall_i = 4'd0;
      end
      req_i = 1'b0;
      #4;
      n_cmp += 2;
      if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL gs_rvalid got=%b want=1", rvalid_o); end
      if (rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL gs_rdata got=%h want=deadbeef", rdata_o); end
      tick();
      gnt_stall_i = 4'd3;
      req_i = 1'b1;
      for (int c = 1; c <= 2; c++) begin
         #4;
         n_cmp++;
         if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL gs_drop_gnt_c%0d got=%b want=0", c, gnt_o); end
         tick();
      end
      req_i = 1'b0;
      tick();
      gnt_stall_i = 4'd0;
      req_i = 1'b1;
      #4;
      n_cmp++;
      if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL gs_reload_gnt got=%b want=1", gnt_o); end
      tick();
      req_i = 1'b0;
      tick();
   endtask

   task automatic test_ordering();
      drive(1, 0, 32'h100, 32'h0, 4'hF);
      rvalid_stall_i = 4'd5;
      #4;
      n_cmp++;
      if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL ord_gnt_a got=%b want=1", gnt_o); end
      tick();
      addr_i = 32'h20;
      rvalid_stall_i = 4'd0;
      #4;
      n_cmp++;
      if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL ord_gnt_b got=%b want=1", gnt_o); end
      tick();
      req_i = 1'b0;
      rvalid_stall_i = 4'd9;
      for (int c = 2; c <= 8; c++) begin
         #4;
         n_cmp++;
         if (rvalid_o !== (c == 6 || c == 7)) begin n_fail++; $display("FAIL ord_rvalid_c%0d got=%b want=%b", c, rvalid_o, c == 6 || c == 7); end
         if (c == 6) begin
            n_cmp++;
            if (rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ord_rdata_a got=%h want=deadbeef", rdata_o); end
         end
         if (c == 7) begin
            n_cmp++;
            if (rdata_o !== 32'h11BB33DD) begin n_fail++; $display("FAIL ord_rdata_b got=%h want=11bb33dd", rdata_o); end
         end
         tick();
      end
   endtask

   task automatic test_full_fifo();
      drive(1, 0, 32'h100, 32'h0, 4'hF);
      rvalid_stall_i = 4'd15;
      for (int c = 0; c <= 17; c++) begin
         #4;
         n_cmp += 2;
         if (gnt_o !== (c < 4 || c == 17)) begin n_fail++; $display("FAIL full_gnt_c%0d got=%b want=%b", c, gnt_o, c < 4 || c == 17); end
         if (rvalid_o !== (c == 16)) begin n_fail++; $display("FAIL full_rvalid_c%0d got=%b want=%b", c, rvalid_o, c == 16); end
         if (c == 4) begin
            n_cmp++;
            if (outstanding_o !== 3'd4) begin n_fail++; $display("FAIL full_outst4 got=%0d want=4", outstanding_o); end
         end
         if (c == 16) begin
            n_cmp++;
            if (rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL full_rdata got=%h want=deadbeef", rdata_o); end
         end
         if (c == 17) begin
            n_cmp++;
            if (outstanding_o !== 3'd3) begin n_fail++; $display("FAIL full_outst3 got=%0d want=3", outstanding_o); end
         end
         tick();
      end
      req_i = 1'b0;
   endtask

   task automatic test_async_reset();
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      drive(1, 0, 32'h20, 32'h0, 4'hF);
      rvalid_stall_i = 4'd15;
      tick();
      tick();
      tick();
      req_i = 1'b0;
      #4;
      n_cmp++;
      if (outstanding_o !== 3'd3) begin n_fail++; $display("FAIL ar_outst_pre got=%0d want=3", outstanding_o); end
      #2;
      rst_ni = 1'b0;
      #1;
      n_cmp += 2;
      if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL ar_rvalid got=%b want=0", rvalid_o); end
      if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL ar_outst got=%0d want=0", outstanding_o); end
      tick();
      rst_ni = 1'b1;
      rvalid_stall_i = 4'd0;
      req_i = 1'b1;
      #4;
      n_cmp++;
      if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL ar_gnt got=%b want=1", gnt_o); end
      tick();
      req_i = 1'b0;
      #4;
      n_cmp += 2;
      if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL ar_rvalid_post got=%b want=1", rvalid_o); end
      if (rdata_o !== 32'h11BB33DD) begin n_fail++; $display("FAIL ar_rdata got=%h want=11bb33dd", rdata_o); end
      tick();
   endtask

   initial begin
      rst_ni = 1'b0;
      drive(0, 0, 32'h0, 32'h0, 4'h0);
      gnt_stall_i = 4'd0;
      rvalid_stall_i = 4'd0;
      test_reset();
      test_zero_stall();
      test_byte_en();
      test_grant_stall();
      test_ordering();
      test_full_fifo();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
